// File: rtl/svc_soc_lifecycle.sv
// SoC run-lifecycle controller: holds the CPU in reset, runs it under a watchdog,
// and captures the exit code written to the exit register or flags a timeout.
module svc_soc_lifecycle #(
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  parameter int unsigned WATCHDOG_CYCLES   = 500_000,
  parameter logic [31:0] EXIT_ADDR         = 32'h8000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_wr_valid,
  input  logic [31:0] mmio_wr_addr,
  input  logic [31:0] mmio_wr_data,
  input  logic [3:0]  mmio_wr_strb,
  input  logic        wd_kick,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] exit_code,
  output logic [31:0] cycle_count
);

  // state    | meaning
  // S_HOLD   | CPU held in reset for the hold period
  // S_RUN    | CPU running, cycle counter and watchdog active
  // S_EXITED | exit register written, result captured (terminal)
  // S_TIMEDOUT | watchdog expired (terminal)

  localparam int unsigned HOLD_N    = (RESET_HOLD_CYCLES == 0) ? 1 : RESET_HOLD_CYCLES;
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_N - 1);
  localparam logic [31:0] WD_LAST   = 32'(WATCHDOG_CYCLES - 1);
  localparam logic        WD_EN     = (WATCHDOG_CYCLES != 0);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_EXITED, S_TIMEDOUT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_hold_cnt;
  logic [31:0] r_wd_cnt;
  logic        r_cpu_rst_n;
  logic        r_done;
  logic        r_pass;
  logic        r_timeout;
  logic [31:0] r_exit_code;
  logic [31:0] r_cycle_count;

  logic w_exit_wr;
  logic w_wd_expire;
  logic w_hold_last;

  assign w_exit_wr   = (r_state == S_RUN) && mmio_wr_valid &&
                       (mmio_wr_addr == EXIT_ADDR) && (mmio_wr_strb == 4'hF);
  assign w_wd_expire = WD_EN && (r_state == S_RUN) && !wd_kick && (r_wd_cnt == WD_LAST);
  assign w_hold_last = (r_state == S_HOLD) && (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_HOLD;
    else        r_state <= w_state_nxt;
  end

  // Exit write is checked before expiry so it wins a same-cycle collision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOLD:  if (w_hold_last) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_exit_wr)        w_state_nxt = S_EXITED;
        else if (w_wd_expire) w_state_nxt = S_TIMEDOUT;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt    <= '0;
      r_wd_cnt      <= '0;
      r_cpu_rst_n   <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_exit_code   <= '0;
      r_cycle_count <= '0;
    end else begin
      // CPU reset releases on the edge entering RUN and reasserts on the edge leaving it.
      r_cpu_rst_n <= (w_state_nxt == S_RUN);
      case (r_state)
        S_HOLD: r_hold_cnt <= r_hold_cnt + 32'd1;
        S_RUN: begin
          if (r_cycle_count != 32'hFFFF_FFFF) r_cycle_count <= r_cycle_count + 32'd1;
          if (wd_kick || !WD_EN) r_wd_cnt <= '0;
          else                   r_wd_cnt <= r_wd_cnt + 32'd1;
          if (w_exit_wr) begin
            r_done      <= 1'b1;
            r_pass      <= (mmio_wr_data == 32'd0);
            r_exit_code <= mmio_wr_data;
          end else if (w_wd_expire) begin
            r_done      <= 1'b1;
            r_timeout   <= 1'b1;
            r_pass      <= 1'b0;
            r_exit_code <= 32'hFFFF_FFFF;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rst_n   = r_cpu_rst_n;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign exit_code   = r_exit_code;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_svc_soc_lifecycle.sv
// Bench for svc_soc_lifecycle: lifecycle model compared every cycle, plus directed
// scenarios with hand-computed expectations (hold length, exit, timeout, reset).
module tb_svc_soc_lifecycle;

  localparam int unsigned HOLD = 16;
  localparam int unsigned WD   = 8;
  localparam logic [31:0] EXIT = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mmio_wr_valid = 1'b0;
  logic [31:0] mmio_wr_addr = '0;
  logic [31:0] mmio_wr_data = '0;
  logic [3:0]  mmio_wr_strb = '0;
  logic        wd_kick = 1'b0;
  logic        cpu_rst_n, done, pass, timeout;
  logic [31:0] exit_code, cycle_count;

  int checks = 0;
  int errors = 0;

  svc_soc_lifecycle #(
    .RESET_HOLD_CYCLES(HOLD),
    .WATCHDOG_CYCLES  (WD),
    .EXIT_ADDR        (EXIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_wr_addr (mmio_wr_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_wr_strb (mmio_wr_strb),
    .wd_kick      (wd_kick),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .exit_code    (exit_code),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is "hold edges seen", then "running" until a result is latched.
  bit          m_live = 0;
  int          m_hold_seen;
  bit          m_running, m_done, m_pass, m_to;
  logic [31:0] m_code;
  longint      m_cycles;
  int          m_idle;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1; m_hold_seen = 0; m_running = 0; m_done = 0; m_pass = 0; m_to = 0;
      m_code = '0; m_cycles = 0; m_idle = 0;
    end else if (m_live) begin
      if (!m_running && !m_done) begin
        m_hold_seen++;
        if (m_hold_seen >= HOLD) m_running = 1;
      end else if (m_running) begin
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        m_idle = wd_kick ? 0 : m_idle + 1;
        if (mmio_wr_valid && mmio_wr_addr == EXIT && mmio_wr_strb == 4'hF) begin
          m_running = 0; m_done = 1; m_code = mmio_wr_data; m_pass = (mmio_wr_data == 0);
        end else if (WD != 0 && m_idle == WD) begin
          m_running = 0; m_done = 1; m_to = 1; m_code = 32'hFFFF_FFFF; m_pass = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model cpu_rst_n",   32'(cpu_rst_n),   32'(m_running));
      chk("model done",        32'(done),        32'(m_done));
      chk("model pass",        32'(pass),        32'(m_pass));
      chk("model timeout",     32'(timeout),     32'(m_to));
      chk("model exit_code",   exit_code,        m_code);
      chk("model cycle_count", cycle_count,      m_cycles[31:0]);
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic k);
    mmio_wr_valid = v; mmio_wr_addr = a; mmio_wr_data = d; mmio_wr_strb = s; wd_kick = k;
    @(negedge clk);
    mmio_wr_valid = 1'b0; wd_kick = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    chk("reset cpu_rst_n",   32'(cpu_rst_n), 32'd0);
    chk("reset done",        32'(done),      32'd0);
    chk("reset pass",        32'(pass),      32'd0);
    chk("reset timeout",     32'(timeout),   32'd0);
    chk("reset exit_code",   exit_code,      32'd0);
    chk("reset cycle_count", cycle_count,    32'd0);
    rst_n = 1'b1;
  endtask

  // Returns in the first RUN cycle; counts cycles with the CPU held in reset.
  task automatic wait_run(output int n);
    n = 0;
    while (cpu_rst_n == 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("wait_run bound", 32'(n), 32'(HOLD));
  endtask

  initial begin
    int n;
    @(negedge clk);
    do_reset(3);
    wait_run(n);
    chk("hold length", 32'(n), 32'd16);
    chk("cpu_rst_n released", 32'(cpu_rst_n), 32'd1);

    // Exit 0 in the 100th RUN cycle, with ignored writes along the way.
    for (int i = 0; i < 99; i++) begin
      if (i == 20)      drive(1'b1, EXIT, 32'd3, 4'h1, (i % 4) == 0);
      else if (i == 40) drive(1'b1, 32'h8000_0014, 32'd3, 4'hF, (i % 4) == 0);
      else              drive(1'b0, '0, '0, 4'h0, (i % 4) == 0);
    end
    chk("no early done", 32'(done), 32'd0);
    drive(1'b1, EXIT, 32'd0, 4'hF, 1'b0);
    chk("exit0 done",        32'(done),      32'd1);
    chk("exit0 pass",        32'(pass),      32'd1);
    chk("exit0 exit_code",   exit_code,      32'd0);
    chk("exit0 cycle_count", cycle_count,    32'd100);
    chk("exit0 cpu_rst_n",   32'(cpu_rst_n), 32'd0);
    for (int i = 0; i < 12; i++) drive(1'b1, EXIT, 32'd7, 4'hF, 1'b0);
    chk("terminal exit_code",   exit_code,   32'd0);
    chk("terminal cycle_count", cycle_count, 32'd100);
    chk("terminal timeout",     32'(timeout), 32'd0);

    // Mid-RUN reset restarts the whole hold sequence.
    do_reset(2);
    wait_run(n);
    for (int i = 0; i < 10; i++) drive(1'b0, '0, '0, 4'h0, 1'b1);
    do_reset(1);
    wait_run(n);
    chk("hold length after mid-run reset", 32'(n), 32'd16);
    drive(1'b1, EXIT, 32'd3, 4'h1, 1'b1);
    drive(1'b1, 32'h8000_0014, 32'd3, 4'hF, 1'b1);
    chk("ignored writes done", 32'(done), 32'd0);
    drive(1'b1, EXIT, 32'd3, 4'hF, 1'b0);
    chk("exit3 done",      32'(done), 32'd1);
    chk("exit3 pass",      32'(pass), 32'd0);
    chk("exit3 exit_code", exit_code, 32'd3);

    // No kicks: timeout after 8 RUN cycles.
    do_reset(2);
    wait_run(n);
    n = 0;
    while (!timeout && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout run cycles", 32'(n),      32'd8);
    chk("timeout done",       32'(done),   32'd1);
    chk("timeout pass",       32'(pass),   32'd0);
    chk("timeout exit_code",  exit_code,   32'hFFFF_FFFF);
    chk("timeout cycles",     cycle_count, 32'd8);
    repeat (5) drive(1'b1, EXIT, 32'd0, 4'hF, 1'b0);
    chk("timeout terminal", exit_code, 32'hFFFF_FFFF);

    // Kick every 7 cycles: never times out.
    do_reset(2);
    wait_run(n);
    for (int i = 0; i < 60; i++) drive(1'b0, '0, '0, 4'h0, (i % 7) == 6);
    chk("kicked timeout", 32'(timeout), 32'd0);
    chk("kicked done",    32'(done),    32'd0);
    chk("kicked cycles",  cycle_count,  32'd60);

    // Exit write lands in the expiry cycle.
    do_reset(2);
    wait_run(n);
    repeat (7) drive(1'b0, '0, '0, 4'h0, 1'b0);
    drive(1'b1, EXIT, 32'd5, 4'hF, 1'b0);
    chk("collision timeout",   32'(timeout), 32'd0);
    chk("collision done",      32'(done),    32'd1);
    chk("collision exit_code", exit_code,    32'd5);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1, "time limit");
  end

endmodule
